mux_sel_seq: RTL and testbench

MUX_SEL_SEQ -- requirements
Module: mux_sel_seq

---
 rtl/mux_sel_pkg.sv | 40 ++++
 rtl/rr_pick.sv | 26 ++
 rtl/mux_sel_seq.sv | 100 ++++++++++
 tb/tb_mux_sel_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared definitions for the round-robin select sequencer: FSM states, source
// indices and the source-to-{sl2,sl1} mapping for the two-stage 2:1 mux chain.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;

    // {sl2, sl1}: sl1 picks a/b in the first stage, sl2 picks stage1/c in the second.
    function automatic logic [1:0] src_to_sel(input logic [1:0] src);
        logic [1:0] sel;
        case (src)
            SRC_B:   sel = 2'b01;
            SRC_C:   sel = 2'b10;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    function automatic logic [2:0] src_to_onehot(input logic [1:0] src);
        logic [2:0] oh;
        case (src)
            SRC_B:   oh = 3'b010;
            SRC_C:   oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

    function automatic logic [1:0] next_src(input logic [1:0] src);
        return (src == SRC_C) ? SRC_A : src + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches the three sources starting just
// after i_last_src, wrapping c back to a.
module rr_pick (
    input  logic [2:0] i_req,
    input  logic [1:0] i_last_src,
    output logic [1:0] o_winner,
    output logic       o_valid
);
    import mux_sel_pkg::*;

    logic [1:0] w_idx;

    always_comb begin
        o_winner = SRC_A;
        o_valid  = 1'b0;
        w_idx    = next_src(i_last_src);
        for (int k = 0; k < 3; k++) begin
            if (!o_valid && i_req[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
            w_idx = next_src(w_idx);
        end
    end

endmodule

// File: rtl/mux_sel_seq.sv
// Round-robin grant sequencer driving the selects of a two-stage 2:1 mux chain.
// Grants last up to DWELL cycles and are always followed by a one-cycle gap.
module mux_sel_seq #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       sl1,
    output logic       sl2,
    output logic [2:0] gnt,
    output logic       busy
);
    import mux_sel_pkg::*;

    localparam int unsigned CntW = $clog2(DWELL + 1);

    if (DWELL == 0 || DWELL > 255) begin : g_bad_dwell
        $error("mux_sel_seq: DWELL must be in 1..255");
    end

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic [1:0]      r_last_src, w_last_src_d;
    logic [1:0]      r_cur_src, w_cur_src_d;
    logic [2:0]      r_gnt, w_gnt_d;
    logic [1:0]      r_sel, w_sel_d;

    logic [1:0]      w_winner;
    logic            w_valid;

    rr_pick u_rr_pick (
        .i_req      (req),
        .i_last_src (r_last_src),
        .o_winner   (w_winner),
        .o_valid    (w_valid)
    );

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_last_src_d = r_last_src;
        w_cur_src_d  = r_cur_src;
        w_gnt_d      = r_gnt;
        w_sel_d      = r_sel;
        unique case (r_state)
            IDLE, GAP: begin
                // Selects are held unless a new grant starts.
                w_gnt_d = '0;
                if (w_valid) begin
                    w_state_d   = GRANT;
                    w_cur_src_d = w_winner;
                    w_gnt_d     = src_to_onehot(w_winner);
                    w_sel_d     = src_to_sel(w_winner);
                    w_cnt_d     = CntW'(1);
                end else begin
                    w_state_d = IDLE;
                end
            end
            GRANT: begin
                if (r_cnt == CntW'(DWELL) || !req[r_cur_src]) begin
                    w_state_d    = GAP;
                    w_gnt_d      = '0;
                    w_last_src_d = r_cur_src;
                    w_cnt_d      = '0;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last_src <= SRC_C;
            r_cur_src  <= SRC_A;
            r_gnt      <= '0;
            r_sel      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_last_src <= w_last_src_d;
            r_cur_src  <= w_cur_src_d;
            r_gnt      <= w_gnt_d;
            r_sel      <= w_sel_d;
        end
    end

    assign gnt  = r_gnt;
    assign sl2  = r_sel[1];
    assign sl1  = r_sel[0];
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq (DWELL=4): constant vector table for reset/rotation,
// hand sequences for multi-cycle corners, and a queued reference model throughout.
module tb_mux_sel_seq;

    localparam int unsigned DWELL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       sl1, sl2, busy;
    logic [2:0] gnt;

    always #5 clk = ~clk;

    mux_sel_seq #(.DWELL(DWELL)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .sl1  (sl1),
        .sl2  (sl2),
        .gnt  (gnt),
        .busy (busy)
    );

    // Existing mux chain: a,b -> stage 1; stage 1, c -> stage 2.
    logic src_a = 1'b1;
    logic src_b = 1'b0;
    logic src_c = 1'b1;
    logic w_stage1, w_chain;
    assign w_stage1 = sl1 ? src_b : src_a;
    assign w_chain  = sl2 ? src_c : w_stage1;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: 0 idle, 1 grant, 2 gap.
    int         m_st = 0;
    int         m_cnt = 0;
    int         m_last = 2;
    int         m_cur = 0;
    logic [2:0] m_gnt = 3'b000;
    logic [1:0] m_sel = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic [2:0] q);
        if (r) begin
            m_st = 0; m_gnt = 3'b000; m_sel = 2'b00; m_cnt = 0; m_last = 2;
        end else if (m_st == 1) begin
            if (m_cnt >= DWELL || q[m_cur] == 1'b0) begin
                m_st = 2; m_gnt = 3'b000; m_last = m_cur; m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            int w;
            w = -1;
            for (int k = 1; k <= 3; k++)
                if (w < 0 && q[(m_last + k) % 3]) w = (m_last + k) % 3;
            if (w >= 0) begin
                m_st  = 1;
                m_cur = w;
                m_gnt = 3'b001 << w;
                m_sel = (w == 2) ? 2'b10 : (w == 1) ? 2'b01 : 2'b00;
                m_cnt = 1;
            end else begin
                m_st  = 0;
                m_gnt = 3'b000;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the model's prediction, compare after the edge.
    task automatic step(input logic r, input logic [2:0] q);
        exp_t e;
        logic exp_val;
        rst = r;
        req = q;
        model(r, q);
        sb_q.push_back('{gnt: m_gnt, sel: m_sel, busy: (m_st != 0)});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_gnt", {29'd0, gnt}, {29'd0, e.gnt});
            check("sb_sel", {30'd0, sl2, sl1}, {30'd0, e.sel});
            check("sb_busy", {31'd0, busy}, {31'd0, e.busy});
            if (e.gnt != 3'b000) begin
                exp_val = e.gnt[0] ? src_a : e.gnt[1] ? src_b : src_c;
                check("chain_out", {31'd0, w_chain}, {31'd0, exp_val});
            end
        end
    endtask

    initial begin
        logic [2:0] oh;
        logic [1:0] sel;

        // Reset with all requests up, then steady rotation a -> b -> c -> a.
        tbl.push_back('{1'b1, 3'b111, 3'b000, 2'b00, 1'b0});
        tbl.push_back('{1'b1, 3'b111, 3'b000, 2'b00, 1'b0});
        for (int s = 0; s < 3; s++) begin
            oh  = 3'b001 << s;
            sel = (s == 2) ? 2'b10 : (s == 1) ? 2'b01 : 2'b00;
            for (int c = 0; c < 4; c++) tbl.push_back('{1'b0, 3'b111, oh, sel, 1'b1});
            tbl.push_back('{1'b0, 3'b111, 3'b000, sel, 1'b1});
        end
        tbl.push_back('{1'b0, 3'b111, 3'b001, 2'b00, 1'b1});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req);
            check("tbl_gnt", {29'd0, gnt}, {29'd0, tbl[i].gnt});
            check("tbl_sel", {30'd0, sl2, sl1}, {30'd0, tbl[i].sel});
            check("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].busy});
        end

        // Early release of b: two grant cycles, gap, then idle.
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);
        check("early_g1", {29'd0, gnt}, 32'h2);
        step(1'b0, 3'b010);
        check("early_g2", {29'd0, gnt}, 32'h2);
        step(1'b0, 3'b000);
        check("early_gap_gnt", {29'd0, gnt}, 32'h0);
        check("early_gap_busy", {31'd0, busy}, 32'h1);
        check("early_gap_sl1", {31'd0, sl1}, 32'h1);
        step(1'b0, 3'b000);
        check("early_idle_busy", {31'd0, busy}, 32'h0);

        // Single continuous requester c: 4 on, 1 off, sl2 held through gaps.
        step(1'b1, 3'b000);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 3'b100);
            check("single_gnt", {29'd0, gnt}, (i % 5 == 4) ? 32'h0 : 32'h4);
            check("single_sl2", {31'd0, sl2}, 32'h1);
        end

        // Reset in grant cycle 2 of b; afterwards a wins first.
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);
        step(1'b0, 3'b010);
        step(1'b1, 3'b011);
        check("rstmid_gnt", {29'd0, gnt}, 32'h0);
        check("rstmid_sl1", {31'd0, sl1}, 32'h0);
        check("rstmid_busy", {31'd0, busy}, 32'h0);
        step(1'b0, 3'b011);
        check("rstmid_first_a", {29'd0, gnt}, 32'h1);

        // Other requests rising mid-grant do not disturb it; drop of a releases.
        step(1'b1, 3'b000);
        step(1'b0, 3'b001);
        step(1'b0, 3'b111);
        check("hold_a", {29'd0, gnt}, 32'h1);
        step(1'b0, 3'b110);
        check("release_a", {29'd0, gnt}, 32'h0);
        step(1'b0, 3'b110);
        check("next_b", {29'd0, gnt}, 32'h2);

        // Random traffic with occasional reset, checked by the model only.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 31) == 0, 3'($urandom_range(0, 7)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
